// File: rtl/setup_sweep_ctrl_if.sv
// Harness-side bundle for the setup-window sweep sequencer: start/offset request,
// the vigilador Alarm input, the generated FF stimulus and the sweep results.
interface setup_sweep_ctrl_if #(
    parameter int OFS_W = 6
);
    logic             start;
    logic [OFS_W-1:0] ofs_max;
    logic             Alarm;
    logic             CLK_FF;
    logic             D_FF;
    logic             busy;
    logic             done;
    logic [OFS_W-1:0] ofs_fail;
    logic             fail_found;
    logic [7:0]       alarm_cnt;

    // Test harness / FF model side
    modport master (
        output start, ofs_max, Alarm,
        input  CLK_FF, D_FF, busy, done, ofs_fail, fail_found, alarm_cnt
    );

    // Sequencer side
    modport slave (
        input  start, ofs_max, Alarm,
        output CLK_FF, D_FF, busy, done, ofs_fail, fail_found, alarm_cnt
    );
endinterface

// File: rtl/setup_sweep_ctrl.sv
// Setup-window sweep sequencer. Generates CLK_FF from CLK, launches a D_FF toggle
// ofs ticks before each CLK_FF rise, scores Alarm over N_REP periods per offset and
// walks ofs downward until the first violating offset (or zero) is reached.
module setup_sweep_ctrl #(
    parameter int PERIOD = 64,
    parameter int OFS_W  = 6,
    parameter int N_REP  = 4
) (
    input  logic                CLK,
    input  logic                nCLR,
    setup_sweep_ctrl_if.slave   bus
);
    localparam int HALF = PERIOD / 2;
    localparam int PH_W = $clog2(PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EVAL, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PH_W-1:0]  r_ph;
    logic [7:0]       r_rep;
    logic [7:0]       r_acnt;
    logic [OFS_W-1:0] r_ofs;
    logic             r_clk_ff;
    logic             r_d_ff;
    logic [OFS_W-1:0] r_ofs_fail;
    logic             r_fail_found;
    logic [7:0]       r_alarm_cnt;

    logic             w_ph_wrap;
    logic             w_last_rep;
    logic             w_busy;
    logic             w_done;
    logic             w_busy_nxt;
    logic [PH_W-1:0]  w_ph_nxt;
    logic [PH_W-1:0]  w_tgl_ph;
    logic             w_clk_nxt;
    logic             w_d_tgl;
    logic [OFS_W-1:0] w_ofs_ld;

    assign w_ph_wrap  = (r_ph == PH_W'(PERIOD - 1));
    assign w_last_rep = (r_rep == 8'(N_REP));
    assign w_ofs_ld   = (bus.ofs_max > OFS_W'(HALF)) ? OFS_W'(HALF) : bus.ofs_max;
    // Phase at which D_FF toggles so that it lands exactly r_ofs ticks before ph wraps
    assign w_tgl_ph   = (r_ofs == '0) ? '0 : PH_W'(PERIOD - int'(r_ofs));

    // State register
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_RUN;
            S_RUN:  if (w_ph_wrap && w_last_rep) w_state_nxt = S_EVAL;
            S_EVAL: begin
                if (r_acnt != 8'd0 || r_ofs == '0) w_state_nxt = S_DONE;
                else                               w_state_nxt = S_RUN;
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status decode and next values of the phase, clock and data stimulus
    always_comb begin
        w_busy     = (r_state == S_RUN) || (r_state == S_EVAL);
        w_done     = (r_state == S_DONE);
        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_EVAL);
        w_ph_nxt   = '0;
        if (w_busy && w_busy_nxt) w_ph_nxt = w_ph_wrap ? '0 : r_ph + PH_W'(1);
        w_clk_nxt  = w_busy_nxt && (w_ph_nxt < PH_W'(HALF));
        // No toggle on sweep entry: the first CLK_FF period is warm-up anyway
        w_d_tgl    = w_busy && w_busy_nxt && (w_ph_nxt == w_tgl_ph);
    end

    // Datapath: phase counter, stimulus registers, alarm scoring and results
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_ph         <= '0;
            r_rep        <= 8'd0;
            r_acnt       <= 8'd0;
            r_ofs        <= '0;
            r_clk_ff     <= 1'b0;
            r_d_ff       <= 1'b0;
            r_ofs_fail   <= '0;
            r_fail_found <= 1'b0;
            r_alarm_cnt  <= 8'd0;
        end else begin
            r_ph     <= w_ph_nxt;
            r_clk_ff <= w_clk_nxt;
            if (w_d_tgl) r_d_ff <= ~r_d_ff;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ofs  <= w_ofs_ld;
                        r_rep  <= 8'd0;
                        r_acnt <= 8'd0;
                    end
                end
                S_RUN: begin
                    // Sample half a period after the rise, scored periods only
                    if (r_rep != 8'd0 && r_ph == PH_W'(HALF) && bus.Alarm && r_acnt != 8'hFF)
                        r_acnt <= r_acnt + 8'd1;
                    if (w_ph_wrap && !w_last_rep)
                        r_rep <= r_rep + 8'd1;
                end
                S_EVAL: begin
                    if (r_acnt != 8'd0) begin
                        r_ofs_fail   <= r_ofs;
                        r_fail_found <= 1'b1;
                        r_alarm_cnt  <= r_acnt;
                    end else if (r_ofs == '0) begin
                        r_ofs_fail   <= '0;
                        r_fail_found <= 1'b0;
                        r_alarm_cnt  <= 8'd0;
                    end else begin
                        r_ofs  <= r_ofs - OFS_W'(1);
                        r_rep  <= 8'd0;
                        r_acnt <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.CLK_FF     = r_clk_ff;
    assign bus.D_FF       = r_d_ff;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.ofs_fail   = r_ofs_fail;
    assign bus.fail_found = r_fail_found;
    assign bus.alarm_cnt  = r_alarm_cnt;
endmodule

// File: tb/tb_setup_sweep_ctrl.sv
// Bench for setup_sweep_ctrl: a vigilador-like alarm model reacting to the measured
// D_FF-to-CLK_FF slack, a vector table plus randomized sweeps, waveform timing checks
// and a mid-sweep reset sequence.
module tb_setup_sweep_ctrl;
    localparam int PERIOD = 64;
    localparam int HALF   = PERIOD / 2;
    localparam int N_REP  = 4;
    localparam int OFS_W  = 6;

    typedef struct {
        int ofs_max;
        int thr;
        bit tie1;
        bit restart;
        bit exp_found;
        int exp_ofs;
        int exp_cnt;
        int exp_lat;
    } vec_t;

    logic CLK;
    logic nCLR;
    setup_sweep_ctrl_if #(.OFS_W(OFS_W)) bus ();

    setup_sweep_ctrl #(.PERIOD(PERIOD), .OFS_W(OFS_W), .N_REP(N_REP)) dut (
        .CLK  (CLK),
        .nCLR (nCLR),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n        = 0;
    int last_d, last_rise, done_cnt, done_n, thr;
    bit have_d, have_rise, wave_en, tie1, alarm_lvl, prev_d, prev_clk;
    int dq[$];
    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Observer and alarm model: Alarm goes high at a CLK_FF rise whose preceding
    // D_FF edge was fewer than thr ticks earlier, and holds until the next rise.
    always @(posedge CLK) begin
        int slack;
        n = n + 1;
        #1;
        if (nCLR) begin
            if (bus.D_FF != prev_d) begin
                last_d = n;
                have_d = 1'b1;
            end
            if (bus.CLK_FF && !prev_clk) begin
                slack = have_d ? n - last_d : 1000;
                if (wave_en && bus.busy) begin
                    if (have_rise) begin
                        check("clk_period", n - last_rise, PERIOD);
                        if (dq.size() == 0) check("extra_rise", 1, 0);
                        else check("d_to_rise", n - last_d, dq.pop_front());
                    end
                    have_rise = 1'b1;
                    last_rise = n;
                end
                alarm_lvl = (slack < thr);
            end
            if (!bus.CLK_FF && prev_clk && bus.busy && wave_en)
                check("clk_high", n - last_rise, HALF);
            if (bus.done) begin
                done_cnt++;
                done_n = n;
            end
        end
        bus.Alarm = tie1 | alarm_lvl;
        prev_d    = bus.D_FF;
        prev_clk  = bus.CLK_FF;
    end

    function automatic vec_t model(input int om, input int th);
        vec_t v;
        int o0, k;
        o0 = (om > HALF) ? HALF : om;
        v.ofs_max = om; v.thr = th; v.tie1 = 0; v.restart = 0;
        v.exp_found = 0; v.exp_ofs = 0; v.exp_cnt = 0;
        k = 0;
        for (int o = o0; o >= 0; o--) begin
            k++;
            if (o < th) begin
                v.exp_found = 1; v.exp_ofs = o; v.exp_cnt = N_REP;
                break;
            end
        end
        v.exp_lat = k * (N_REP + 1) * PERIOD + 2;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk_ff"}, int'(bus.CLK_FF), 0);
        check({tag, "_d_ff"}, int'(bus.D_FF), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_ofs_fail"}, int'(bus.ofs_fail), 0);
        check({tag, "_fail_found"}, int'(bus.fail_found), 0);
        check({tag, "_alarm_cnt"}, int'(bus.alarm_cnt), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int s, o0, of;
        o0 = (v.ofs_max > HALF) ? HALF : v.ofs_max;
        of = v.exp_found ? v.exp_ofs : 0;
        dq.delete();
        for (int o = o0; o >= of; o--)
            for (int r = 0; r <= N_REP; r++) dq.push_back(o);
        thr = v.thr; tie1 = v.tie1; alarm_lvl = 0;
        have_d = 0; have_rise = 0; done_cnt = 0; done_n = -1;
        wave_en = 1;
        @(negedge CLK);
        check("busy_before_start", int'(bus.busy), 0);
        bus.ofs_max = OFS_W'(v.ofs_max);
        bus.start   = 1'b1;
        s = n;
        @(negedge CLK);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        if (v.restart) begin
            repeat (100) @(negedge CLK);
            bus.ofs_max = OFS_W'(5);
            bus.start   = 1'b1;
            @(negedge CLK);
            bus.start = 1'b0;
        end
        while (done_cnt == 0 && n < s + v.exp_lat + 50) @(negedge CLK);
        check("done_seen", int'(done_cnt != 0), 1);
        check("latency", done_n - s, v.exp_lat);
        repeat (3) @(negedge CLK);
        wave_en = 0;
        check("done_pulse_len", done_cnt, 1);
        check("busy_after_done", int'(bus.busy), 0);
        check("fail_found", int'(bus.fail_found), int'(v.exp_found));
        check("ofs_fail", int'(bus.ofs_fail), v.exp_ofs);
        check("alarm_cnt", int'(bus.alarm_cnt), v.exp_cnt);
        check("rises_left", dq.size(), 0);
    endtask

    initial begin
        vec_t rv;
        //          ofs_max thr tie1 rst  found ofs cnt lat
        tbl[0] = '{32, 30, 0, 0, 1, 29, 4, 4*5*64+2};
        tbl[1] = '{ 3,  0, 0, 0, 0,  0, 0, 4*5*64+2};
        tbl[2] = '{10,  0, 1, 0, 1, 10, 4, 5*64+2};
        tbl[3] = '{63,  0, 1, 1, 1, 32, 4, 5*64+2};
        tbl[4] = '{ 0,  0, 0, 0, 0,  0, 0, 5*64+2};
        tbl[5] = '{ 0,  1, 0, 0, 1,  0, 4, 5*64+2};
        tbl[6] = '{40, 33, 0, 0, 1, 32, 4, 5*64+2};

        nCLR = 1'b0;
        bus.start = 1'b0;
        bus.ofs_max = '0;
        wave_en = 0; tie1 = 0; thr = 0;
        repeat (3) @(negedge CLK);
        check_reset_vals("por");
        nCLR = 1'b1;
        @(negedge CLK);
        check_reset_vals("idle");

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        for (int i = 0; i < 6; i++) begin
            rv = model(int'($urandom_range(0, 15)), int'($urandom_range(0, 17)));
            run_vec(rv);
        end

        // Mid-sweep reset: outputs clear at once, no done follows, next sweep is clean
        thr = 0; tie1 = 0; alarm_lvl = 0; done_cnt = 0;
        @(negedge CLK);
        bus.ofs_max = OFS_W'(5);
        bus.start   = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        repeat (500) @(negedge CLK);
        check("busy_mid_sweep", int'(bus.busy), 1);
        #2 nCLR = 1'b0;
        #1 check_reset_vals("abort");
        repeat (2) @(negedge CLK);
        nCLR = 1'b1;
        repeat (400) @(negedge CLK);
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", int'(bus.busy), 0);
        run_vec(tbl[2]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
